// File: rtl/seq_count_interval_ctrl_pkg.sv
// Shared definitions for the seq_count interval controller family:
// FSM state encoding, default counter width and small state decode helpers.
package seq_count_interval_ctrl_pkg;

  // Default width of the counter, period input and count output.
  localparam int NBITS_DEF = 3;

  // Two-bit FSM encoding; the numeric values are visible on the debug port.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // An interval is in progress while running or paused.
  function automatic logic state_is_busy(input state_t s);
    logic r;
    case (s)
      ST_RUN:  r = 1'b1;
      ST_HOLD: r = 1'b1;
      ST_IDLE: r = 1'b0;
      ST_DONE: r = 1'b0;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  // The done pulse is exactly the single cycle spent in DONE.
  function automatic logic state_is_done(input state_t s);
    logic r;
    case (s)
      ST_DONE: r = 1'b1;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/seq_count_interval_ctrl_if.sv
// Command/status bundle between an interval requester (master) and the
// interval controller (slave). Clock and reset are carried separately.
interface seq_count_interval_ctrl_if
  import seq_count_interval_ctrl_pkg::*;
#(
  parameter int NBITS = NBITS_DEF
);

  logic             start;   // request a new interval
  logic [NBITS-1:0] period;  // terminal count, latched on an accepted start
  logic             pause;   // level: freeze the counter while busy
  logic             abort;   // cancel any activity
  logic             busy;    // running or paused
  logic             done;    // one-cycle completion pulse
  logic [NBITS-1:0] count;   // current counter value
  logic [1:0]       state;   // debug view of the FSM encoding

  modport master (
    output start, period, pause, abort,
    input  busy, done, count, state
  );

  modport slave (
    input  start, period, pause, abort,
    output busy, done, count, state
  );

endinterface

// File: rtl/seq_count_interval_ctrl_counter.sv
// NBITS binary up-counter with enable and synchronous clear.
// Clear wins over enable; the asynchronous reset returns the count to zero.
module seq_count_nb_bin_up_en_clr
  import seq_count_interval_ctrl_pkg::*;
#(
  parameter int NBITS = NBITS_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             clr,
  output logic [NBITS-1:0] count
);

  localparam logic [NBITS-1:0] CNT_ZERO = {NBITS{1'b0}};
  localparam logic [NBITS-1:0] CNT_ONE  = {{(NBITS-1){1'b0}}, 1'b1};

  logic [NBITS-1:0] count_r;

  // Counter register: clear has priority, otherwise increment when enabled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_r <= CNT_ZERO;
    end else if (clr) begin
      count_r <= CNT_ZERO;
    end else if (en) begin
      count_r <= count_r + CNT_ONE;
    end else begin
      count_r <= count_r;
    end
  end

  assign count = count_r;

endmodule

// File: rtl/seq_count_interval_ctrl.sv
// Interval-timer sequencing controller. Accepts a start with a terminal
// count, runs the counter from 0 up to that value, then pulses done for one
// cycle. Pause freezes the count; abort returns to IDLE without a pulse.
module seq_count_interval_ctrl
  import seq_count_interval_ctrl_pkg::*;
#(
  parameter int NBITS = NBITS_DEF
) (
  input  logic                      clk,
  input  logic                      reset,
  seq_count_interval_ctrl_if.slave  bus
);

  localparam logic [NBITS-1:0] PER_ZERO = {NBITS{1'b0}};

  state_t           state_r;
  state_t           next_s;
  logic [NBITS-1:0] period_r;
  logic [NBITS-1:0] count_s;
  logic             busy_r;
  logic             done_r;
  logic             term_s;
  logic             accept_s;
  logic             cnt_en_s;
  logic             cnt_clr_s;

  // Terminal compare against the period captured at start time.
  assign term_s = (count_s == period_r);

  // Start is honoured only in IDLE, and abort on the same edge cancels it.
  assign accept_s = (state_r == ST_IDLE) && bus.start && !bus.abort;

  // Counter control: count only while running, unpaused and short of the
  // terminal value, so the counter can never wrap past the period.
  assign cnt_en_s  = (state_r == ST_RUN) && !bus.pause && !term_s && !bus.abort;
  assign cnt_clr_s = bus.abort || accept_s || (state_r == ST_DONE);

  seq_count_nb_bin_up_en_clr #(
    .NBITS (NBITS)
  ) u_counter (
    .clk   (clk),
    .reset (reset),
    .en    (cnt_en_s),
    .clr   (cnt_clr_s),
    .count (count_s)
  );

  // Next-state decode; abort overrides every state.
  always_comb begin
    next_s = state_r;
    if (bus.abort) begin
      next_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (bus.start) begin
            next_s = ST_RUN;
          end else begin
            next_s = ST_IDLE;
          end
        end
        ST_RUN: begin
          if (bus.pause) begin
            next_s = ST_HOLD;
          end else if (term_s) begin
            next_s = ST_DONE;
          end else begin
            next_s = ST_RUN;
          end
        end
        ST_HOLD: begin
          if (bus.pause) begin
            next_s = ST_HOLD;
          end else begin
            next_s = ST_RUN;
          end
        end
        ST_DONE: begin
          next_s = ST_IDLE;
        end
        default: begin
          next_s = ST_IDLE;
        end
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_s;
    end
  end

  // Period capture on an accepted start; later changes on the input are ignored.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      period_r <= PER_ZERO;
    end else if (accept_s) begin
      period_r <= bus.period;
    end else begin
      period_r <= period_r;
    end
  end

  // Status flags registered from the next state so they line up with state_r.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      busy_r <= state_is_busy(next_s);
      done_r <= state_is_done(next_s);
    end
  end

  assign bus.busy  = busy_r;
  assign bus.done  = done_r;
  assign bus.count = count_s;
  assign bus.state = state_r;

endmodule

// File: tb/tb_seq_count_interval_ctrl.sv
// Self-checking bench for seq_count_interval_ctrl (NBITS=3): directed
// interval scenarios with literal expectations, then randomized traffic,
// all checked every cycle against a behavioural model of the interval rules.
module tb_seq_count_interval_ctrl;

  localparam int NB = 3;

  logic clk;
  logic reset;

  seq_count_interval_ctrl_if #(.NBITS(NB)) bus ();

  seq_count_interval_ctrl #(.NBITS(NB)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Model phases, numbered as the debug state port reports them.
  localparam int PH_IDLE = 0;
  localparam int PH_RUN  = 1;
  localparam int PH_HOLD = 2;
  localparam int PH_DONE = 3;

  int m_phase;
  int m_cnt;
  int m_per;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model of the interval: applied on each rising edge.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_phase <= PH_IDLE;
      m_cnt   <= 0;
      m_per   <= 0;
    end else if (bus.abort) begin
      m_phase <= PH_IDLE;
      m_cnt   <= 0;
    end else if (m_phase == PH_IDLE && bus.start) begin
      m_phase <= PH_RUN;
      m_per   <= int'(bus.period);
      m_cnt   <= 0;
    end else if (m_phase == PH_RUN && bus.pause) begin
      m_phase <= PH_HOLD;
    end else if (m_phase == PH_RUN) begin
      if (m_cnt >= m_per) m_phase <= PH_DONE;
      else m_cnt <= m_cnt + 1;
    end else if (m_phase == PH_HOLD) begin
      if (!bus.pause) m_phase <= PH_RUN;
    end else if (m_phase == PH_DONE) begin
      m_phase <= PH_IDLE;
      m_cnt   <= 0;
    end
  end

  task automatic cmp(input string nm, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0d, expected %0d", nm, $time, got, exp);
    end
  endtask

  // Per-cycle comparison of every DUT output against the model.
  always @(negedge clk) begin
    cmp("count", 8'(bus.count), 8'(m_cnt));
    cmp("state", 8'(bus.state), 8'(m_phase));
    cmp("busy",  8'(bus.busy),  8'((m_phase == PH_RUN || m_phase == PH_HOLD) ? 1 : 0));
    cmp("done",  8'(bus.done),  8'((m_phase == PH_DONE) ? 1 : 0));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic lit(input string tag, input int c, input int s, input int b, input int d);
    cmp({tag, ".count"}, 8'(bus.count), 8'(c));
    cmp({tag, ".state"}, 8'(bus.state), 8'(s));
    cmp({tag, ".busy"},  8'(bus.busy),  8'(b));
    cmp({tag, ".done"},  8'(bus.done),  8'(d));
  endtask

  // Start an interval and follow it through RUN, DONE and back to IDLE.
  task automatic run_interval(input string tag, input int p);
    bus.start  = 1'b1;
    bus.period = 3'(p);
    step();
    bus.start  = 1'b0;
    bus.period = 3'($urandom_range(0, 7));
    for (int i = 0; i <= p; i++) begin
      lit($sformatf("%s.run%0d", tag, i), i, 1, 1, 0);
      step();
    end
    lit({tag, ".done"}, p, 3, 0, 1);
    step();
    lit({tag, ".idle"}, 0, 0, 0, 0);
  endtask

  initial begin
    reset      = 1'b1;
    bus.start  = 1'b0;
    bus.period = 3'd0;
    bus.pause  = 1'b0;
    bus.abort  = 1'b0;
    step();
    lit("reset", 0, 0, 0, 0);
    step();
    reset = 1'b0;
    step();

    // Basic intervals, including the maximum period (no wrap before done).
    run_interval("t1", 3);
    step();
    run_interval("t2", 7);
    step();

    // Pause for three cycles at count 2.
    bus.start = 1'b1; bus.period = 3'd5;
    step();
    bus.start = 1'b0; bus.period = 3'd1;
    lit("t3.r0", 0, 1, 1, 0); step();
    lit("t3.r1", 1, 1, 1, 0); step();
    lit("t3.r2", 2, 1, 1, 0);
    bus.pause = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      lit($sformatf("t3.hold%0d", i), 2, 2, 1, 0);
    end
    bus.pause = 1'b0;
    step(); lit("t3.resume", 2, 1, 1, 0);
    step(); lit("t3.r3", 3, 1, 1, 0);
    step(); lit("t3.r4", 4, 1, 1, 0);
    step(); lit("t3.r5", 5, 1, 1, 0);
    step(); lit("t3.done", 5, 3, 0, 1);
    step(); lit("t3.idle", 0, 0, 0, 0);

    // Abort at count 4, then abort together with start in IDLE.
    bus.start = 1'b1; bus.period = 3'd7;
    step();
    bus.start = 1'b0;
    repeat (4) step();
    lit("t4.pre", 4, 1, 1, 0);
    bus.abort = 1'b1;
    step();
    bus.abort = 1'b0;
    lit("t4.abort", 0, 0, 0, 0);
    step(); lit("t4.after", 0, 0, 0, 0);
    bus.start = 1'b1; bus.abort = 1'b1; bus.period = 3'd2;
    step();
    bus.start = 1'b0; bus.abort = 1'b0;
    lit("t4.abst", 0, 0, 0, 0);
    step();

    // Period 0, then a start with period 6 while busy is ignored.
    run_interval("t5a", 0);
    bus.start = 1'b1; bus.period = 3'd2;
    step();
    bus.period = 3'd6;
    lit("t5b.r0", 0, 1, 1, 0); step();
    lit("t5b.r1", 1, 1, 1, 0); step();
    lit("t5b.r2", 2, 1, 1, 0); step();
    lit("t5b.done", 2, 3, 0, 1);
    bus.start = 1'b0;
    step(); lit("t5b.idle", 0, 0, 0, 0);

    // Asynchronous reset mid-RUN takes effect within the cycle.
    bus.start = 1'b1; bus.period = 3'd7;
    step();
    bus.start = 1'b0;
    step(); step();
    lit("t6.pre", 2, 1, 1, 0);
    #2 reset = 1'b1;
    #1 lit("t6.rst", 0, 0, 0, 0);
    step();
    reset = 1'b0;
    step();

    // Randomized traffic against the model.
    for (int i = 0; i < 300; i++) begin
      bus.start  = ($urandom_range(0, 1) == 1);
      bus.period = 3'($urandom_range(0, 7));
      bus.pause  = ($urandom_range(0, 3) == 0);
      bus.abort  = ($urandom_range(0, 15) == 0);
      reset      = ($urandom_range(0, 31) == 0);
      step();
    end
    reset = 1'b0; bus.start = 1'b0; bus.pause = 1'b0; bus.abort = 1'b0;
    repeat (3) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
